// File: rtl/seg7_scan_ctrl_if.sv
// Load/status bus between the counter/datapath logic and the 7-segment scan
// controller.
//   load : 1-cycle strobe, capture data into the pending buffer
//   data : packed BCD nibbles, digit k = data[4k+3:4k], digit 0 = rightmost
//   pend : pending buffer holds a value that has not been displayed yet
//   upd  : 1-cycle pulse, the displayed (active) buffer was just updated
// master = datapath side, slave = scan controller side.
interface seg7_scan_ctrl_if #(
    parameter int N_DIGIT = 4
);
    logic                   load;
    logic [4*N_DIGIT-1:0]   data;
    logic                   pend;
    logic                   upd;

    modport master (output load, output data, input pend, input upd);
    modport slave  (input load, input data, output pend, output upd);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// A loaded value is held in a pending buffer and only copied to the displayed
// buffer at a frame boundary, so a frame never shows a mix of old and new
// digits. Each digit is lit for SHOW_CYC clocks followed by GAP_CYC dark clocks.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         scan enable, low = display dark
//   i_lz_blank   leading-zero suppression enable
//   bus          load/data in, pend/upd out (seg7_scan_ctrl_if.slave)
//   o_digit_sel  one-hot digit select, active-high
//   o_seg        segment pattern {a,b,c,d,e,f,g}, 1 = lit
module seg7_scan_ctrl #(
    parameter int N_DIGIT  = 4,
    parameter int SHOW_CYC = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_lz_blank,
    seg7_scan_ctrl_if.slave     bus,
    output logic [N_DIGIT-1:0]  o_digit_sel,
    output logic [6:0]          o_seg
);
    localparam int MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(N_DIGIT);
    localparam int DW      = 4 * N_DIGIT;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGIT - 1);

    typedef enum logic [1:0] {S_OFF, S_SHOW, S_GAP} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [DW-1:0]        r_active;
    logic [DW-1:0]        r_pending;
    logic                 r_pend;
    logic                 r_upd;
    logic [N_DIGIT-1:0]   r_sel;
    logic [6:0]           r_seg;

    state_t               w_state_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_boundary;
    logic                 w_xfer;
    logic [DW-1:0]        w_active_next;
    logic [DW-1:0]        w_pending_next;
    logic                 w_pend_next;
    logic [3:0]           w_nib [N_DIGIT];
    logic [N_DIGIT-1:0]   w_lead_zero;
    logic                 w_blank;
    logic [N_DIGIT-1:0]   w_sel_next;
    logic [6:0]           w_seg_next;

    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h70;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Next-state logic. w_boundary marks entry to S_SHOW on digit 0, the only
    // point where the displayed buffer may change.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_boundary   = 1'b0;
        if (!i_en) begin
            w_state_next = S_OFF;
            w_idx_next   = '0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_next = S_SHOW;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                    w_boundary   = 1'b1;
                end
                S_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_next = S_GAP;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_next = S_SHOW;
                        w_cnt_next   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_next = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_OFF;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // The transfer uses the pending value from before this cycle's load, so a
    // load landing on the boundary is kept for the following frame.
    assign w_xfer         = w_boundary & r_pend;
    assign w_active_next  = w_xfer ? r_pending : r_active;
    assign w_pending_next = bus.load ? bus.data : r_pending;
    assign w_pend_next    = bus.load | (r_pend & ~w_xfer);

    // Digit k (k>0) is a leading zero when it and every digit above it are 0.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGIT; gi++) begin : g_digit
            assign w_nib[gi] = w_active_next[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign w_lead_zero[gi] = 1'b0;
            end else begin : g_upper
                assign w_lead_zero[gi] = (w_active_next[DW-1:4*gi] == '0);
            end
        end
    endgenerate

    // Outputs are computed from next state and registered, so the pins are
    // driven straight from flops; i_lz_blank is sampled every clock.
    assign w_blank    = i_lz_blank & w_lead_zero[w_idx_next];
    assign w_sel_next = (w_state_next == S_SHOW)
                      ? ({{(N_DIGIT-1){1'b0}}, 1'b1} << w_idx_next) : '0;
    assign w_seg_next = (w_state_next == S_SHOW && !w_blank)
                      ? enc(w_nib[w_idx_next]) : 7'h00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_OFF;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_active  <= '0;
            r_pending <= '0;
            r_pend    <= 1'b0;
            r_upd     <= 1'b0;
            r_sel     <= '0;
            r_seg     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_cnt     <= w_cnt_next;
            r_active  <= w_active_next;
            r_pending <= w_pending_next;
            r_pend    <= w_pend_next;
            r_upd     <= w_xfer;
            r_sel     <= w_sel_next;
            r_seg     <= w_seg_next;
        end
    end

    assign bus.pend    = r_pend;
    assign bus.upd     = r_upd;
    assign o_digit_sel = r_sel;
    assign o_seg       = r_seg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGIT=4, SHOW_CYC=4, GAP_CYC=2
// (24-clock frame). Inputs change and outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       lz;
    logic [3:0] sel;
    logic [6:0] seg;
    int         checks = 0;
    int         errors = 0;

    seg7_scan_ctrl_if #(.N_DIGIT(4)) bus ();

    seg7_scan_ctrl #(.N_DIGIT(4), .SHOW_CYC(4), .GAP_CYC(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_lz_blank  (lz),
        .bus         (bus),
        .o_digit_sel (sel),
        .o_seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at its first S_SHOW cycle (current
    // falling edge). segs = {d3,d2,d1,d0}. Up to two loads can be issued at
    // frame cycles la and lb. Returns at the first cycle of the next frame.
    task automatic run_frame(input string name, input logic [27:0] segs,
                             input logic eu, input logic ep,
                             input int la, input logic [15:0] da,
                             input int lb, input logic [15:0] db);
        logic pe;
        pe = ep;
        for (int t = 0; t < 24; t++) begin
            int d;
            int c;
            logic [3:0] es;
            logic [6:0] eg;
            d  = t / 6;
            c  = t % 6;
            es = (c < 4) ? (4'b0001 << d) : 4'b0000;
            eg = (c < 4) ? segs[7*d +: 7] : 7'h00;
            chk($sformatf("%s t%0d sel", name, t), 32'(sel), 32'(es));
            chk($sformatf("%s t%0d seg", name, t), 32'(seg), 32'(eg));
            chk($sformatf("%s t%0d upd", name, t), 32'(bus.upd), (t == 0) ? 32'(eu) : 32'd0);
            chk($sformatf("%s t%0d pend", name, t), 32'(bus.pend), 32'(pe));
            bus.load = (t == la) || (t == lb);
            if (t == la) bus.data = da;
            if (t == lb) bus.data = db;
            if (bus.load) pe = 1'b1;
            @(negedge clk);
        end
        bus.load = 1'b0;
        $display("frame %s checked", name);
    endtask

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        lz       = 1'b0;
        bus.load = 1'b0;
        bus.data = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst sel", 32'(sel), 32'd0);
        chk("rst seg", 32'(seg), 32'd0);
        chk("rst pend", 32'(bus.pend), 32'd0);
        chk("rst upd", 32'(bus.upd), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst hold sel", 32'(sel), 32'd0);
        rst_n = 1'b1;

        // Load before enabling: pending only, display stays dark.
        @(negedge clk);
        bus.load = 1'b1;
        bus.data = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        chk("load pend", 32'(bus.pend), 32'd1);
        chk("load upd", 32'(bus.upd), 32'd0);
        chk("load sel", 32'(sel), 32'd0);
        $display("load 1234 while off");
        en = 1'b1;
        @(negedge clk);

        // 1234 -> d0=33 d1=79 d2=6D d3=30; first frame carries the update.
        run_frame("f1_1234", {7'h30, 7'h6D, 7'h79, 7'h33}, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
        // Second frame unchanged; load 5678 mid-frame keeps old digits.
        run_frame("f2_1234", {7'h30, 7'h6D, 7'h79, 7'h33}, 1'b0, 1'b0, 3, 16'h5678, -1, 16'h0);
        lz = 1'b1;
        // 5678 -> d0=7F d1=70 d2=5F d3=5B; queue 0042.
        run_frame("f3_5678", {7'h5B, 7'h5F, 7'h70, 7'h7F}, 1'b1, 1'b0, 7, 16'h0042, -1, 16'h0);
        // 0042 with blanking -> d0=6D d1=33 d2=00 d3=00; queue 0000 late.
        run_frame("f4_0042", {7'h00, 7'h00, 7'h33, 7'h6D}, 1'b1, 1'b0, 20, 16'h0000, -1, 16'h0);
        // 0000 with blanking -> only digit 0 lit.
        run_frame("f5_0000", {7'h00, 7'h00, 7'h00, 7'h7E}, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
        lz = 1'b0;
        // Blanking off: all zeros shown. Load 0907, then 3AB1 on the boundary.
        run_frame("f6_0000", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 1'b0, 1'b0, 5, 16'h0907, 23, 16'h3AB1);
        // 0907 shown, 3AB1 still pending for the whole frame.
        run_frame("f7_0907", {7'h7E, 7'h7B, 7'h7E, 7'h70}, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
        // 3AB1 -> d0=30, nibbles B/A blank, d3=79.
        run_frame("f8_3AB1", {7'h79, 7'h00, 7'h00, 7'h30}, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

        // Disable while digit 2 is lit.
        repeat (13) @(negedge clk);
        chk("d2 sel", 32'(sel), 32'h4);
        en = 1'b0;
        @(negedge clk);
        chk("off sel", 32'(sel), 32'd0);
        chk("off seg", 32'(seg), 32'd0);
        repeat (3) @(negedge clk);
        chk("off hold sel", 32'(sel), 32'd0);
        $display("disable mid digit 2");
        en = 1'b1;
        @(negedge clk);
        chk("reen sel", 32'(sel), 32'h1);
        chk("reen seg", 32'(seg), 32'h30);
        chk("reen upd", 32'(bus.upd), 32'd0);
        $display("re-enable at digit 0");

        // Async reset during the gap with a pending value.
        bus.load = 1'b1;
        bus.data = 16'h1111;
        @(negedge clk);
        bus.load = 1'b0;
        chk("gap pend pre", 32'(bus.pend), 32'd1);
        repeat (3) @(negedge clk);
        chk("gap sel pre", 32'(sel), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst pend", 32'(bus.pend), 32'd0);
        chk("arst upd", 32'(bus.upd), 32'd0);
        chk("arst sel", 32'(sel), 32'd0);
        chk("arst seg", 32'(seg), 32'd0);
        $display("async reset in gap");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post sel", 32'(sel), 32'h1);
        chk("post seg", 32'(seg), 32'h7E);
        chk("post upd", 32'(bus.upd), 32'd0);
        chk("post pend", 32'(bus.pend), 32'd0);
        $display("restart after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
